// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//
// Purpose:
//   Shared constants and types for the single-clock byte FIFO (sync_fifo)
//   and its storage array (fifo_mem).
//
// Contents:
//   DATA_WIDTH  default width of one stored word (8)
//   ADDR_WIDTH  default address bits; usable depth is 2**ADDR_WIDTH (16)
//   MEM_SIZE    default number of storage entries (32); entries at or above
//               2**ADDR_WIDTH exist but are never addressed
//   DEPTH       usable depth derived from ADDR_WIDTH
//   fifo_ptr_t  read/write pointer: ADDR_WIDTH address bits plus a wrap bit
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int MEM_SIZE   = 32;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    // The extra MSB is the wrap bit. It lets equal low bits be told apart
    // as either "nothing stored" (wrap bits equal) or "every entry stored"
    // (wrap bits differ) without a separate occupancy counter.
    typedef logic [ADDR_WIDTH:0] fifo_ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//
// Purpose:
//   Storage array behind sync_fifo. One synchronous write port and one
//   asynchronous (combinational) read port, so the FIFO head word is
//   visible in the same cycle its read address is presented.
//   The array has no reset; stale contents are unreachable once the
//   FIFO pointers are cleared.
//
// Ports:
//   CLK        in   1           write clock (rising edge)
//   i_wrEn     in   1           write enable for this edge
//   i_wrAddr   in   ADDR_WIDTH  write address
//   i_wrData   in   DATA_WIDTH  write data
//   i_rdAddr   in   ADDR_WIDTH  read address
//   o_rdData   out  DATA_WIDTH  MEM[i_rdAddr], combinational
// ---------------------------------------------------------------------------
module fifo_mem #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int MEM_SIZE   = fifo_pkg::MEM_SIZE
) (
    input  logic                  CLK,
    input  logic                  i_wrEn,
    input  logic [ADDR_WIDTH-1:0] i_wrAddr,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    input  logic [ADDR_WIDTH-1:0] i_rdAddr,
    output logic [DATA_WIDTH-1:0] o_rdData
);

    import fifo_pkg::*;

    // The array may be deeper than the FIFO address range, so the index
    // width follows the array size and the FIFO address is zero-extended
    // into it. Only the low 2**ADDR_WIDTH entries are ever touched.
    localparam int MEM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [DATA_WIDTH-1:0] MEM [MEM_SIZE-1:0];
    logic [MEM_AW-1:0]     w_wrIndex;
    logic [MEM_AW-1:0]     w_rdIndex;

    assign w_wrIndex = MEM_AW'(i_wrAddr);
    assign w_rdIndex = MEM_AW'(i_rdAddr);

    // Write port: one word stored per enabled rising edge. No reset so the
    // array can map onto plain RAM/LUT storage.
    always_ff @(posedge CLK) begin
        if (i_wrEn) begin
            MEM[w_wrIndex] <= i_wrData;
        end
    end

    // Read port: purely combinational so the FIFO can present its head
    // word without waiting for a read strobe.
    assign o_rdData = MEM[w_rdIndex];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Purpose:
//   Single-clock first-word-fall-through FIFO for byte-wide packet data.
//   Each accepted write pushes one word, each accepted read pops one.
//   FULL and EMPTY give back-pressure; writes while FULL and reads while
//   EMPTY are silently ignored. The head word is always visible on
//   RD_DATA (0 while EMPTY). Depth 16 absorbs a 10-byte burst while the
//   consumer drains more slowly.
//
// Ports:
//   CLK      in   1           single clock, rising edge
//   RST      in   1           synchronous active-high reset (pointers -> 0)
//   W_INC    in   1           write request; push WR_DATA on this edge
//   WR_DATA  in   DATA_WIDTH  write data
//   FULL     out  1           no free entry; writes are dropped
//   R_INC    in   1           read request; pop the head word on this edge
//   RD_DATA  out  DATA_WIDTH  head word, 0 while EMPTY
//   EMPTY    out  1           no stored word; reads are dropped
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int MEM_SIZE   = fifo_pkg::MEM_SIZE
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  FULL,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  EMPTY
);

    import fifo_pkg::*;

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;

    logic [ADDR_WIDTH-1:0] Wr_ADDR;
    logic [ADDR_WIDTH-1:0] Rd_ADDR;

    logic                  w_writeAccept;
    logic                  w_readAccept;
    logic                  w_memWrEn;
    logic [DATA_WIDTH-1:0] w_memRdData;

    // Storage addresses are the pointers without their wrap bit.
    assign Wr_ADDR = r_wptr[ADDR_WIDTH-1:0];
    assign Rd_ADDR = r_rptr[ADDR_WIDTH-1:0];

    // Flags come straight from the registered pointers, so they only change
    // just after a clock edge and never glitch on input activity.
    // Equal pointers mean nothing stored; equal addresses with opposite
    // wrap bits mean the writer is a full lap ahead of the reader.
    assign EMPTY = (r_wptr == r_rptr);
    assign FULL  = (Wr_ADDR == Rd_ADDR) && (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]);

    // A request is only honoured if the flag seen before the edge allows
    // it. At FULL a simultaneous read still pops while the write is dropped;
    // at EMPTY a simultaneous write still pushes while the read is dropped.
    assign w_writeAccept = W_INC && !FULL;
    assign w_readAccept  = R_INC && !EMPTY;

    // Reset wins over a write on the same edge, so the array is not
    // disturbed by a word that is logically discarded anyway.
    assign w_memWrEn = w_writeAccept && !RST;

    // Write pointer: advances once per accepted write and wraps naturally
    // through both the address bits and the wrap bit. Reset returns it to 0,
    // which discards everything buffered without clearing the array.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr <= '0;
        end else if (w_writeAccept) begin
            r_wptr <= r_wptr + PTR_ONE;
        end
    end

    // Read pointer: advances once per accepted read. Because the array read
    // is combinational, the next word appears on RD_DATA in the same cycle
    // the pointer moves, with no extra latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rptr <= '0;
        end else if (w_readAccept) begin
            r_rptr <= r_rptr + PTR_ONE;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) FIFO_MEMORY (
        .CLK      (CLK),
        .i_wrEn   (w_memWrEn),
        .i_wrAddr (Wr_ADDR),
        .i_wrData (WR_DATA),
        .i_rdAddr (Rd_ADDR),
        .o_rdData (w_memRdData)
    );

    // The head word is masked to 0 while empty so stale array contents
    // never leak onto the output.
    assign RD_DATA = EMPTY ? '0 : w_memRdData;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//
// Purpose:
//   Self-checking bench for sync_fifo. A table of short vectors covers the
//   basic push/pop/flag behaviour, hand-written sequences cover the
//   multi-cycle corners (packet, full, underflow, wrap, reset mid-stream),
//   and a randomized run is compared against a queue-based model.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

    import fifo_pkg::*;

    logic       CLK;
    logic       RST;
    logic       W_INC;
    logic [7:0] WR_DATA;
    logic       FULL;
    logic       R_INC;
    logic [7:0] RD_DATA;
    logic       EMPTY;

    int testsRun;
    int testsFailed;

    // Reference model: the FIFO contents as a plain queue, head at index 0.
    logic [7:0] model[$];

    typedef struct {
        logic       rst;
        logic       winc;
        logic [7:0] wdata;
        logic       rinc;
        logic       expEmpty;
        logic       expFull;
        logic [7:0] expRd;
    } vec_t;

    vec_t vecs[10];

    sync_fifo dut (
        .CLK     (CLK),
        .RST     (RST),
        .W_INC   (W_INC),
        .WR_DATA (WR_DATA),
        .FULL    (FULL),
        .R_INC   (R_INC),
        .RD_DATA (RD_DATA),
        .EMPTY   (EMPTY)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Guard against a hung run: report and stop hard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached (actual=running, required=finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the DUT's visible state with the queue model.
    task automatic checkModel(input string tag);
        logic [7:0] expHead;
        expHead = (model.size() != 0) ? model[0] : 8'h00;
        checkOutput({tag, "_empty"}, 32'(EMPTY), 32'(model.size() == 0));
        checkOutput({tag, "_full"}, 32'(FULL), 32'(model.size() == DEPTH));
        checkOutput({tag, "_rddata"}, 32'(RD_DATA), 32'(expHead));
    endtask

    // Drive one cycle of inputs, advance the model by the FIFO rules using
    // the occupancy before the edge, then sample 1 ns after the edge.
    task automatic applyStimulus(input logic rst, input logic winc, input logic [7:0] wdata, input logic rinc);
        bit canRead;
        bit canWrite;
        RST     = rst;
        W_INC   = winc;
        WR_DATA = wdata;
        R_INC   = rinc;
        canRead  = (model.size() != 0);
        canWrite = (model.size() < DEPTH);
        if (rst) begin
            model.delete();
        end else begin
            if (rinc && canRead) begin
                void'(model.pop_front());
            end
            if (winc && canWrite) begin
                model.push_back(wdata);
            end
        end
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        W_INC = 1'b0;
        R_INC = 1'b0;
    endtask

    initial begin
        logic [7:0] pkt[10];
        logic [7:0] burst[5];
        logic [7:0] b;
        int         occ;
        int         wPct;
        bit         sawAA;

        testsRun    = 0;
        testsFailed = 0;
        RST     = 1'b1;
        W_INC   = 1'b0;
        WR_DATA = 8'h00;
        R_INC   = 1'b0;

        // ---------------- 1. reset state ----------------
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("reset_empty", 32'(EMPTY), 32'd1);
        checkOutput("reset_full", 32'(FULL), 32'd0);
        checkOutput("reset_rddata", 32'(RD_DATA), 32'd0);
        checkOutput("reset_wraddr", 32'(dut.Wr_ADDR), 32'd0);
        checkOutput("reset_rdaddr", 32'(dut.Rd_ADDR), 32'd0);

        // ---------------- table-driven basics ----------------
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[2] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[3] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h22};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 8'h44};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[9] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].winc, vecs[i].wdata, vecs[i].rinc);
            checkOutput($sformatf("vec%0d_empty", i), 32'(EMPTY), 32'(vecs[i].expEmpty));
            checkOutput($sformatf("vec%0d_full", i), 32'(FULL), 32'(vecs[i].expFull));
            checkOutput($sformatf("vec%0d_rddata", i), 32'(RD_DATA), 32'(vecs[i].expRd));
        end

        // ---------------- 2. 10-byte packet ----------------
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            pkt[i] = 8'($urandom_range(0, 255));
            applyStimulus(1'b0, 1'b1, pkt[i], 1'b0);
            checkOutput($sformatf("pkt_mem%0d", i), 32'(dut.FIFO_MEMORY.MEM[i]), 32'(pkt[i]));
            checkOutput($sformatf("pkt_wraddr%0d", i), 32'(dut.Wr_ADDR), 32'(i + 1));
            checkOutput($sformatf("pkt_head%0d", i), 32'(RD_DATA), 32'(pkt[0]));
        end
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("pkt_rd%0d", i), 32'(RD_DATA), 32'(pkt[i]));
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("pkt_empty_after", 32'(EMPTY), 32'd1);

        // ---------------- 3. full and overflow ----------------
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("fill_notfull%0d", i), 32'(FULL), 32'd0);
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
        end
        checkOutput("full_flag", 32'(FULL), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
        checkOutput("overflow_full", 32'(FULL), 32'd1);
        checkOutput("overflow_wraddr", 32'(dut.Wr_ADDR), 32'd0);
        sawAA = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("full_rd%0d", i), 32'(RD_DATA), 32'(i));
            if (RD_DATA == 8'hAA) sawAA = 1'b1;
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("full_drained_empty", 32'(EMPTY), 32'd1);
        checkOutput("full_no_aa", 32'(sawAA), 32'd0);

        // ---------------- 4. underflow ----------------
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("under_rdaddr%0d", i), 32'(dut.Rd_ADDR), 32'd0);
            checkOutput($sformatf("under_rddata%0d", i), 32'(RD_DATA), 32'd0);
            checkOutput($sformatf("under_empty%0d", i), 32'(EMPTY), 32'd1);
        end

        // ---------------- 5. wrap and simultaneous access ----------------
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            burst[i] = 8'($urandom_range(0, 255));
            applyStimulus(1'b0, 1'b1, burst[i], 1'b0);
        end
        checkOutput("wrap_wraddr", 32'(dut.Wr_ADDR), 32'd5);
        checkOutput("wrap_head", 32'(RD_DATA), 32'(burst[0]));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'hC0 + i), 1'b1);
            occ = (int'(dut.Wr_ADDR) - int'(dut.Rd_ADDR) + 16) % 16;
            checkOutput($sformatf("simul_occ%0d", i), 32'(occ), 32'd5);
            checkModel($sformatf("simul%0d", i));
        end
        checkOutput("simul_head", 32'(RD_DATA), 32'(burst[4]));
        while (model.size() < DEPTH) applyStimulus(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        checkOutput("both_pre_full", 32'(FULL), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
        checkOutput("both_at_full_flag", 32'(FULL), 32'd0);
        checkModel("both_at_full");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkModel($sformatf("drain%0d", i));
        end
        checkOutput("drain_empty", 32'(EMPTY), 32'd1);

        // ---------------- 6. reset mid-operation ----------------
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        checkModel("pre_midreset");
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
        checkOutput("midreset_empty", 32'(EMPTY), 32'd1);
        checkOutput("midreset_full", 32'(FULL), 32'd0);
        checkOutput("midreset_rddata", 32'(RD_DATA), 32'd0);
        checkOutput("midreset_wraddr", 32'(dut.Wr_ADDR), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("midreset_still_empty", 32'(EMPTY), 32'd1);

        // ---------------- randomized run against the model ----------------
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            wPct = ((i / 150) % 2 == 0) ? 75 : 25;
            b = 8'($urandom_range(0, 255));
            applyStimulus(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < wPct) ? 1'b1 : 1'b0,
                          b,
                          ($urandom_range(0, 99) < (100 - wPct)) ? 1'b1 : 1'b0);
            checkModel("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_sync_fifo
